// File: rtl/result_slot_pkg.sv
// Shared types and default constants for the result-slot allocator.
package result_slot_pkg;

   typedef enum logic [1:0] {
      ANNOUNCE = 2'd0,
      WAIT     = 2'd1,
      STALL    = 2'd2
   } slot_state_t;

   localparam int unsigned RESULT_SLOT_STRIDE = 1550;
   localparam int unsigned RESULT_NUM_SLOTS   = 5;

endpackage

// File: rtl/result_slot_allocator_if.sv
// Matcher/reader-facing bus of the result-slot allocator; err_* exist only with RESULT_SLOT_ERR_EN.
// The consumer release strobe is release_slot because "release" is a reserved word.
interface result_slot_allocator_if
   import result_slot_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned NUM_SLOTS = RESULT_NUM_SLOTS
);
   localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
   localparam int unsigned CNT_W  = $clog2(NUM_SLOTS + 1);

   logic              inc_addr;
   logic              release_slot;
   logic [ADDR_W-1:0] addr_out;
   logic              write_enable;
   logic [SLOT_W-1:0] wr_slot;
   logic [SLOT_W-1:0] rd_slot;
   logic [CNT_W-1:0]  count;
   logic              full;
`ifdef RESULT_SLOT_ERR_EN
   logic              err_overflow;
   logic              err_underflow;
`endif

   modport master (
`ifdef RESULT_SLOT_ERR_EN
      input  err_overflow, err_underflow,
`endif
      output inc_addr, release_slot,
      input  addr_out, write_enable, wr_slot, rd_slot, count, full
   );

   modport slave (
`ifdef RESULT_SLOT_ERR_EN
      output err_overflow, err_underflow,
`endif
      input  inc_addr, release_slot,
      output addr_out, write_enable, wr_slot, rd_slot, count, full
   );

endinterface

// File: rtl/slot_ptr_addr.sv
// Wrapping slot index plus matching base-address accumulator (no multiplier).
module slot_ptr_addr
   import result_slot_pkg::*;
#(
   parameter int unsigned     ADDR_W      = 32,
   parameter int unsigned     NUM_SLOTS   = RESULT_NUM_SLOTS,
   parameter longint unsigned BASE_ADDR   = 0,
   parameter int unsigned     SLOT_STRIDE = RESULT_SLOT_STRIDE
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         advance,
   output logic [$clog2(NUM_SLOTS)-1:0] slot,
   output logic [ADDR_W-1:0]            addr
);
   localparam int unsigned           SLOT_W    = $clog2(NUM_SLOTS);
   localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
   localparam logic [ADDR_W-1:0]     ADDR_BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0]     ADDR_STEP = ADDR_W'(SLOT_STRIDE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot <= '0;
         addr <= ADDR_BASE;
      end else if (advance) begin
         if (slot == SLOT_LAST) begin
            slot <= '0;
            addr <= ADDR_BASE;
         end else begin
            slot <= slot + 1'b1;
            addr <= addr + ADDR_STEP;
         end
      end
   end

endmodule

// File: rtl/result_slot_allocator.sv
// Output-FIFO write-slot allocator with occupancy tracking against consumer releases.
// Optional sticky error flags: define RESULT_SLOT_ERR_EN.
module result_slot_allocator
   import result_slot_pkg::*;
#(
   parameter int unsigned     ADDR_W      = 32,
   parameter int unsigned     NUM_SLOTS   = RESULT_NUM_SLOTS,
   parameter longint unsigned BASE_ADDR   = 0,
   parameter int unsigned     SLOT_STRIDE = RESULT_SLOT_STRIDE
) (
   input logic                    clk,
   input logic                    rst,
   result_slot_allocator_if.slave bus
);
   localparam int unsigned       SLOT_W    = $clog2(NUM_SLOTS);
   localparam int unsigned       CNT_W     = $clog2(NUM_SLOTS + 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(NUM_SLOTS);

   slot_state_t      state, state_nxt;
   logic             accept;
   logic             rel_ok;
   logic [CNT_W-1:0] count_nxt;

   always_comb begin
      accept    = (state == WAIT) && bus.inc_addr;
      rel_ok    = bus.release_slot && (bus.count != '0);
      count_nxt = bus.count + CNT_W'(accept) - CNT_W'(rel_ok);
      state_nxt = state;
      unique case (state)
         // ANNOUNCE with write_enable still low only happens right after reset:
         // hold one cycle so the first grant pulses on the first edge.
         ANNOUNCE: state_nxt = bus.write_enable ? WAIT : ANNOUNCE;
         WAIT:     if (accept) state_nxt = (count_nxt < CNT_MAX) ? ANNOUNCE : STALL;
         STALL:    if (bus.count < CNT_MAX) state_nxt = ANNOUNCE;
         default:  state_nxt = ANNOUNCE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= ANNOUNCE;
         bus.write_enable <= 1'b0;
         bus.rd_slot      <= '0;
         bus.count        <= '0;
         bus.full         <= 1'b0;
      end else begin
         state            <= state_nxt;
         bus.write_enable <= (state_nxt == ANNOUNCE);
         bus.count        <= count_nxt;
         bus.full         <= (count_nxt == CNT_MAX);
         if (rel_ok)
            bus.rd_slot <= (bus.rd_slot == SLOT_LAST) ? '0 : bus.rd_slot + 1'b1;
      end
   end

   slot_ptr_addr #(
      .ADDR_W      (ADDR_W),
      .NUM_SLOTS   (NUM_SLOTS),
      .BASE_ADDR   (BASE_ADDR),
      .SLOT_STRIDE (SLOT_STRIDE)
   ) u_wr_ptr (
      .clk     (clk),
      .rst     (rst),
      .advance (accept),
      .slot    (bus.wr_slot),
      .addr    (bus.addr_out)
   );

`ifdef RESULT_SLOT_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.err_overflow  <= 1'b0;
         bus.err_underflow <= 1'b0;
      end else begin
         if (bus.inc_addr && (state != WAIT))
            bus.err_overflow <= 1'b1;
         if (bus.release_slot && (bus.count == '0))
            bus.err_underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_result_slot_allocator.sv
// Self-checking bench for result_slot_allocator: directed scenarios then random traffic vs a slot-level model.
module tb_result_slot_allocator;
   import result_slot_pkg::*;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned N      = 5;
   localparam longint unsigned BASE = 0;
   localparam int unsigned STRIDE = 1550;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   result_slot_allocator_if #(.ADDR_W(ADDR_W), .NUM_SLOTS(N)) bus ();

   result_slot_allocator #(
      .ADDR_W      (ADDR_W),
      .NUM_SLOTS   (N),
      .BASE_ADDR   (BASE),
      .SLOT_STRIDE (STRIDE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: slot occupancy ring plus the grant/wait/blocked phase of the writer.
   int m_count, m_wr, m_rd;
   bit m_we, m_waiting, m_blocked, m_first, m_of, m_uf;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_count = 0; m_wr = 0; m_rd = 0;
      m_we = 0; m_waiting = 0; m_blocked = 0; m_first = 1;
      m_of = 0; m_uf = 0;
   endtask

   task automatic model_edge(input bit inc, input bit rel);
      int acc, relv, nc;
      bit g;
      acc  = (m_waiting && inc) ? 1 : 0;
      relv = (rel && m_count > 0) ? 1 : 0;
      if (inc && !m_waiting) m_of = 1;
      if (rel && m_count == 0) m_uf = 1;
      nc = m_count + acc - relv;
      g  = 0;
      if (m_first) begin
         g = 1; m_first = 0;
      end else if (m_we) begin
         m_waiting = 1;
      end else if (acc == 1) begin
         m_waiting = 0;
         if (nc < N) g = 1; else m_blocked = 1;
      end else if (m_blocked && m_count < N) begin
         m_blocked = 0; g = 1;
      end
      if (acc == 1) m_wr = (m_wr + 1) % N;
      if (relv == 1) m_rd = (m_rd + 1) % N;
      m_count = nc;
      m_we = g;
   endtask

   task automatic check_outputs(input string tag);
      logic [ADDR_W-1:0] ea;
      ea = ADDR_W'(BASE + longint'(m_wr) * STRIDE);
      chk({tag, "_we"},    bus.write_enable, 64'(m_we));
      chk({tag, "_addr"},  bus.addr_out,     64'(ea));
      chk({tag, "_wr"},    bus.wr_slot,      64'(m_wr));
      chk({tag, "_rd"},    bus.rd_slot,      64'(m_rd));
      chk({tag, "_count"}, bus.count,        64'(m_count));
      chk({tag, "_full"},  bus.full,         64'(m_count == N));
`ifdef RESULT_SLOT_ERR_EN
      chk({tag, "_eovf"},  bus.err_overflow,  64'(m_of));
      chk({tag, "_eudf"},  bus.err_underflow, 64'(m_uf));
`endif
   endtask

   task automatic step(input bit inc, input bit rel, input string tag);
      bus.inc_addr     = inc;
      bus.release_slot = rel;
      @(posedge clk);
      model_edge(inc, rel);
      #1;
      check_outputs(tag);
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs("rst_async");
      bus.inc_addr     = 1'b0;
      bus.release_slot = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_outputs("rst_hold");
      rst = 1'b0;
   endtask

   initial begin
      bus.inc_addr     = 1'b0;
      bus.release_slot = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_outputs("reset");
      rst = 1'b0;

      // first grant after reset release
      step(0, 0, "t1_grant");
      chk("t1_we", bus.write_enable, 64'd1);
      chk("t1_addr", bus.addr_out, 64'd0);
      step(0, 0, "t1_idle");
      chk("t1_we_drop", bus.write_enable, 64'd0);

      // four fills spaced three clocks apart
      for (int i = 0; i < 4; i++) begin
         step(1, 0, "t2_inc");
         chk("t2_addr", bus.addr_out, 64'(1550 * (i + 1)));
         chk("t2_we", bus.write_enable, 64'd1);
         step(0, 0, "t2_idle");
         step(0, 0, "t2_idle");
      end
      chk("t2_count", bus.count, 64'd4);
      chk("t2_full", bus.full, 64'd0);

      // fifth fill stalls, release frees the wrapped slot
      step(1, 0, "t3_fill");
      chk("t3_full", bus.full, 64'd1);
      chk("t3_we", bus.write_enable, 64'd0);
      chk("t3_addr", bus.addr_out, 64'd0);
      step(0, 0, "t3_stall");
      step(0, 1, "t3_rel");
      chk("t3_count", bus.count, 64'd4);
      chk("t3_rd", bus.rd_slot, 64'd1);
      step(0, 0, "t3_regrant");
      chk("t3_we_wrap", bus.write_enable, 64'd1);
      chk("t3_addr_wrap", bus.addr_out, 64'd0);

      // simultaneous fill and release at count 2
      step(0, 0, "t4_idle");
      step(0, 1, "t4_rel");
      step(0, 1, "t4_rel");
      chk("t4_count_pre", bus.count, 64'd2);
      step(1, 1, "t4_both");
      chk("t4_count", bus.count, 64'd2);
      chk("t4_wr", bus.wr_slot, 64'd1);
      chk("t4_rd", bus.rd_slot, 64'd4);
      chk("t4_we", bus.write_enable, 64'd1);

      // refill to STALL, then reset mid-operation
      step(0, 0, "t6_idle");
      for (int i = 0; i < 3; i++) begin
         step(1, 0, "t6_fill");
         step(0, 0, "t6_idle");
      end
      chk("t6_full", bus.full, 64'd1);
      async_reset();
      step(0, 0, "t6_grant");
      chk("t6_we", bus.write_enable, 64'd1);
      chk("t6_count", bus.count, 64'd0);

      // illegal events: fill during announce, release when empty
      step(1, 1, "t5_illegal");
      chk("t5_wr", bus.wr_slot, 64'd0);
      chk("t5_count", bus.count, 64'd0);
`ifdef RESULT_SLOT_ERR_EN
      chk("t5_eovf", bus.err_overflow, 64'd1);
      chk("t5_eudf", bus.err_underflow, 64'd1);
      repeat (3) step(0, 0, "t5_sticky");
      chk("t5_eovf_sticky", bus.err_overflow, 64'd1);
      async_reset();
      chk("t5_eovf_clr", bus.err_overflow, 64'd0);
      chk("t5_eudf_clr", bus.err_underflow, 64'd0);
`endif

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 249) == 0)
            async_reset();
         else if (i % 500 < 250)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, "rnd");
         else
            step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
